vpi_param_responder: RTL and testbench

Hardware responder for VPI-style parameter enumeration. It holds a table of parameter descriptors for one module instance and serves three kinds of request: iterator creation (iterate), iterator advance (scan) and property reads (get). It sits behind a request/response handshake driven by a testbench-side initiator. Handles mirror VPI semantics: a null handle is 0, and an iterator is freed when it returns null.

---
 rtl/vpi_param_pkg.sv | 34 +++
 rtl/param_desc_table.sv | 48 ++++
 rtl/vpi_param_responder.sv | 206 ++++++++++++++++++++
 tb/tb_vpi_param_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vpi_param_pkg.sv
// Shared types and constants for the VPI parameter responder.
package vpi_param_pkg;

  localparam int DESC_VALUE_W = 32;

  localparam logic [7:0] VPI_PARAMETER = 8'd41;
  localparam logic [7:0] VPI_MODULE    = 8'd32;

  typedef enum logic [1:0] {
    OP_ITERATE = 2'd0,
    OP_SCAN    = 2'd1,
    OP_GET     = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    PROP_TYPE  = 2'd0,
    PROP_NAME  = 2'd1,
    PROP_VALUE = 2'd2
  } prop_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic                    valid;
    logic [7:0]              type_code;
    logic [15:0]             name_id;
    logic [DESC_VALUE_W-1:0] value;
  } param_desc_t;

endpackage

// File: rtl/param_desc_table.sv
// Parameter descriptor storage: registered cfg write port, asynchronous read port.
module param_desc_table
  import vpi_param_pkg::*;
#(
  parameter int NUM_PARAMS = 4,
  parameter int VALUE_W    = 32,
  localparam int IDX_W     = $clog2(NUM_PARAMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_valid,
  input  logic [7:0]         cfg_type,
  input  logic [15:0]        cfg_name_id,
  input  logic [VALUE_W-1:0] cfg_value,
  input  logic [IDX_W-1:0]   rd_idx,
  output param_desc_t        rd_desc,
  output logic               any_valid
);

  param_desc_t table_r [NUM_PARAMS];

  // Descriptor storage; writes become visible to readers on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        table_r[i] <= '0;
      end
    end else if (cfg_we) begin
      table_r[cfg_idx] <= '{valid:     cfg_valid,
                            type_code: cfg_type,
                            name_id:   cfg_name_id,
                            value:     DESC_VALUE_W'(cfg_value)};
    end
  end

  assign rd_desc = table_r[rd_idx];

  // Reduction of valid bits, used to answer ITERATE on an empty table.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      any_valid = any_valid | table_r[i].valid;
    end
  end

endmodule

// File: rtl/vpi_param_responder.sv
// VPI-style parameter enumeration responder: iterator slots, request FSM and response registers.
module vpi_param_responder
  import vpi_param_pkg::*;
#(
  parameter int NUM_PARAMS = 4,
  parameter int NUM_ITERS  = 2,
  parameter int VALUE_W    = 32,
  localparam int IDX_W     = $clog2(NUM_PARAMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_valid,
  input  logic [7:0]         cfg_type,
  input  logic [15:0]        cfg_name_id,
  input  logic [VALUE_W-1:0] cfg_value,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [7:0]         req_handle,
  input  logic [1:0]         req_prop,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [VALUE_W-1:0] rsp_data,
  output logic               rsp_err
);

  localparam int CUR_W  = $clog2(NUM_PARAMS + 1);
  localparam int SLOT_W = (NUM_ITERS > 1) ? $clog2(NUM_ITERS) : 1;
  localparam logic [CUR_W-1:0]   CUR_MAX   = CUR_W'(NUM_PARAMS);
  localparam logic [7:0]         NP_H      = 8'(NUM_PARAMS);
  localparam logic [7:0]         NI_H      = 8'(NUM_ITERS);
  localparam logic [VALUE_W-1:0] ZERO_DATA = {VALUE_W{1'b0}};

  state_e               state_r, state_s;
  logic [NUM_ITERS-1:0] busy_r, busy_s;
  logic [CUR_W-1:0]     cursor_r [NUM_ITERS];
  logic [CUR_W-1:0]     cursor_s [NUM_ITERS];
  logic [SLOT_W-1:0]    cur_slot_r, cur_slot_s;
  logic                 rsp_valid_r, rsp_valid_s;
  logic [VALUE_W-1:0]   rsp_data_r, rsp_data_s;
  logic                 rsp_err_r, rsp_err_s;

  logic [IDX_W-1:0]  rd_idx_s;
  param_desc_t       rd_desc_s;
  logic              any_valid_s;
  logic [CUR_W-1:0]  srch_cursor_s, next_cursor_s;
  logic [SLOT_W-1:0] scan_slot_s, free_idx_s;
  logic              free_found_s, scan_ok_s, get_ok_s;
  logic [7:0]        free_handle_s;

  param_desc_table #(
    .NUM_PARAMS (NUM_PARAMS),
    .VALUE_W    (VALUE_W)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_valid   (cfg_valid),
    .cfg_type    (cfg_type),
    .cfg_name_id (cfg_name_id),
    .cfg_value   (cfg_value),
    .rd_idx      (rd_idx_s),
    .rd_desc     (rd_desc_s),
    .any_valid   (any_valid_s)
  );

  assign srch_cursor_s = cursor_r[cur_slot_r];
  assign next_cursor_s = srch_cursor_s + CUR_W'(1);
  // The single read port follows the cursor while searching and the request handle otherwise.
  assign rd_idx_s      = (state_r == ST_SEARCH) ? IDX_W'(srch_cursor_s) : IDX_W'(req_handle - 8'd1);
  assign scan_slot_s   = SLOT_W'(req_handle - 8'd1);
  assign scan_ok_s     = (req_handle != 8'd0) && (req_handle <= NI_H) && busy_r[scan_slot_s];
  assign get_ok_s      = (req_handle != 8'd0) && (req_handle <= NP_H) && rd_desc_s.valid;
  assign free_handle_s = 8'(free_idx_s) + 8'd1;

  // Lowest-numbered free iterator slot (descending scan so the lowest index wins).
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = {SLOT_W{1'b0}};
    for (int i = NUM_ITERS - 1; i >= 0; i--) begin
      free_idx_s   = busy_r[i] ? free_idx_s : SLOT_W'(i);
      free_found_s = free_found_s | ~busy_r[i];
    end
  end

  // Next-state and next-register logic for the request FSM.
  always_comb begin
    state_s     = state_r;
    busy_s      = busy_r;
    cursor_s    = cursor_r;
    cur_slot_s  = cur_slot_r;
    rsp_valid_s = rsp_valid_r;
    rsp_data_s  = rsp_data_r;
    rsp_err_s   = rsp_err_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_s     = ST_RESP;
          rsp_valid_s = 1'b1;
          rsp_data_s  = ZERO_DATA;
          rsp_err_s   = 1'b0;
          case (op_e'(req_op))
            OP_ITERATE: begin
              if (!any_valid_s) begin
                rsp_data_s = ZERO_DATA;
              end else if (free_found_s) begin
                busy_s[free_idx_s]   = 1'b1;
                cursor_s[free_idx_s] = {CUR_W{1'b0}};
                rsp_data_s           = VALUE_W'(free_handle_s);
              end else begin
                rsp_err_s = 1'b1;
              end
            end
            OP_SCAN: begin
              if (scan_ok_s) begin
                state_s     = ST_SEARCH;
                rsp_valid_s = 1'b0;
                cur_slot_s  = scan_slot_s;
              end else begin
                rsp_err_s = 1'b1;
              end
            end
            OP_GET: begin
              if (get_ok_s) begin
                case (prop_e'(req_prop))
                  PROP_TYPE:  rsp_data_s = VALUE_W'(rd_desc_s.type_code);
                  PROP_NAME:  rsp_data_s = VALUE_W'(rd_desc_s.name_id);
                  PROP_VALUE: rsp_data_s = VALUE_W'(rd_desc_s.value);
                  default:    rsp_err_s  = 1'b1;
                endcase
              end else begin
                rsp_err_s = 1'b1;
              end
            end
            default: rsp_err_s = 1'b1;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (srch_cursor_s == CUR_MAX) begin
          busy_s[cur_slot_r] = 1'b0;
          state_s            = ST_RESP;
          rsp_valid_s        = 1'b1;
          rsp_data_s         = ZERO_DATA;
          rsp_err_s          = 1'b0;
        end else if (rd_desc_s.valid) begin
          cursor_s[cur_slot_r] = next_cursor_s;
          state_s              = ST_RESP;
          rsp_valid_s          = 1'b1;
          rsp_data_s           = VALUE_W'(next_cursor_s);
          rsp_err_s            = 1'b0;
        end else begin
          cursor_s[cur_slot_r] = next_cursor_s;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_s = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          rsp_valid_s = 1'b1;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        rsp_valid_s = 1'b0;
      end
    endcase
  end

  // State, iterator slots and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      busy_r      <= {NUM_ITERS{1'b0}};
      cur_slot_r  <= {SLOT_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= ZERO_DATA;
      rsp_err_r   <= 1'b0;
      for (int i = 0; i < NUM_ITERS; i++) begin
        cursor_r[i] <= {CUR_W{1'b0}};
      end
    end else begin
      state_r     <= state_s;
      busy_r      <= busy_s;
      cur_slot_r  <= cur_slot_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      rsp_err_r   <= rsp_err_s;
      for (int i = 0; i < NUM_ITERS; i++) begin
        cursor_r[i] <= cursor_s[i];
      end
    end
  end

  assign req_ready = (state_r == ST_IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_vpi_param_responder.sv
// Directed self-checking bench for vpi_param_responder.
module tb_vpi_param_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic        cfg_valid;
  logic [7:0]  cfg_type;
  logic [15:0] cfg_name_id;
  logic [31:0] cfg_value;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_handle;
  logic [1:0]  req_prop;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vpi_param_responder #(.NUM_PARAMS(4), .NUM_ITERS(2), .VALUE_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_valid   (cfg_valid),
    .cfg_type    (cfg_type),
    .cfg_name_id (cfg_name_id),
    .cfg_value   (cfg_value),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_handle  (req_handle),
    .req_prop    (req_prop),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] idx, input logic v, input logic [7:0] t,
                     input logic [15:0] nm, input logic [31:0] val);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx; cfg_valid = v;
    cfg_type = t; cfg_name_id = nm; cfg_value = val;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] h, input logic [1:0] p);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_handle = h; req_prop = p;
  endtask

  // Latency counts negedges after the accepting posedge; 99 marks a timeout.
  task automatic wait_rsp(output logic [31:0] d, output logic e, output int lat);
    @(negedge clk);
    req_valid = 1'b0;
    cfg_we    = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = 99;
    d = rsp_data;
    e = rsp_err;
  endtask

  task automatic xact(input string tag, input logic [1:0] op, input logic [7:0] h,
                      input logic [1:0] p, input logic [31:0] exp_d,
                      input logic exp_e, input int exp_lat);
    logic [31:0] d;
    logic        e;
    int          lat;
    send(op, h, p);
    wait_rsp(d, e, lat);
    check({tag, ".data"}, d, exp_d);
    check({tag, ".err"}, 32'(e), 32'(exp_e));
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = 2'd0; cfg_valid = 1'b0; cfg_type = 8'd0;
    cfg_name_id = 16'd0; cfg_value = 32'd0; req_valid = 1'b0; req_op = 2'd0;
    req_handle = 8'd0; req_prop = 2'd0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_data", rsp_data, 32'd0);
    check("rst.rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;

    // Full table walk
    cfg(2'd0, 1'b1, 8'd41, 16'd10, 32'd1);
    cfg(2'd1, 1'b1, 8'd41, 16'd11, 32'd101);
    cfg(2'd2, 1'b1, 8'd41, 16'd12, 32'd102);
    cfg(2'd3, 1'b1, 8'd41, 16'd13, 32'd103);
    xact("it1", 2'd0, 8'd1, 2'd0, 32'd1, 1'b0, 1);
    xact("sc1", 2'd1, 8'd1, 2'd0, 32'd1, 1'b0, 2);
    xact("sc2", 2'd1, 8'd1, 2'd0, 32'd2, 1'b0, 2);
    xact("sc3", 2'd1, 8'd1, 2'd0, 32'd3, 1'b0, 2);
    xact("sc4", 2'd1, 8'd1, 2'd0, 32'd4, 1'b0, 2);
    xact("sc5", 2'd1, 8'd1, 2'd0, 32'd0, 1'b0, 2);
    xact("sc6", 2'd1, 8'd1, 2'd0, 32'd0, 1'b1, 1);
    xact("sc_h0", 2'd1, 8'd0, 2'd0, 32'd0, 1'b1, 1);
    xact("sc_h3", 2'd1, 8'd3, 2'd0, 32'd0, 1'b1, 1);

    // Sparse table: skipped entries lengthen SEARCH
    cfg(2'd1, 1'b0, 8'd41, 16'd11, 32'd101);
    cfg(2'd2, 1'b0, 8'd41, 16'd12, 32'd102);
    xact("it2", 2'd0, 8'd0, 2'd0, 32'd1, 1'b0, 1);
    xact("sp1", 2'd1, 8'd1, 2'd0, 32'd1, 1'b0, 2);
    xact("sp4", 2'd1, 8'd1, 2'd0, 32'd4, 1'b0, 4);
    xact("sp0", 2'd1, 8'd1, 2'd0, 32'd0, 1'b0, 2);

    // Property reads
    xact("get_val", 2'd2, 8'd1, 2'd2, 32'd1, 1'b0, 1);
    xact("get_type", 2'd2, 8'd1, 2'd0, 32'd41, 1'b0, 1);
    xact("get_name", 2'd2, 8'd4, 2'd1, 32'd13, 1'b0, 1);
    xact("get_val4", 2'd2, 8'd4, 2'd2, 32'd103, 1'b0, 1);
    xact("get_h5", 2'd2, 8'd5, 2'd0, 32'd0, 1'b1, 1);
    xact("get_h0", 2'd2, 8'd0, 2'd0, 32'd0, 1'b1, 1);
    xact("get_p3", 2'd2, 8'd1, 2'd3, 32'd0, 1'b1, 1);
    xact("get_inv", 2'd2, 8'd2, 2'd0, 32'd0, 1'b1, 1);
    xact("op3", 2'd3, 8'd1, 2'd0, 32'd0, 1'b1, 1);

    // GET racing a cfg write to the same entry sees the old value
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_valid = 1'b1; cfg_type = 8'd41;
    cfg_name_id = 16'd10; cfg_value = 32'd7;
    req_valid = 1'b1; req_op = 2'd2; req_handle = 8'd1; req_prop = 2'd2;
    wait_rsp(d, e, lat);
    check("race.old", d, 32'd1);
    check("race.lat", 32'(lat), 32'd1);
    xact("race.new", 2'd2, 8'd1, 2'd2, 32'd7, 1'b0, 1);

    // Slot exhaustion and reuse
    xact("its1", 2'd0, 8'd0, 2'd0, 32'd1, 1'b0, 1);
    xact("its2", 2'd0, 8'd0, 2'd0, 32'd2, 1'b0, 1);
    xact("its3", 2'd0, 8'd0, 2'd0, 32'd0, 1'b1, 1);
    xact("ex1", 2'd1, 8'd1, 2'd0, 32'd1, 1'b0, 2);
    xact("ex4", 2'd1, 8'd1, 2'd0, 32'd4, 1'b0, 4);
    xact("ex0", 2'd1, 8'd1, 2'd0, 32'd0, 1'b0, 2);
    xact("its4", 2'd0, 8'd0, 2'd0, 32'd1, 1'b0, 1);

    // Empty table: worst-case scan, then ITERATE allocates nothing
    cfg(2'd0, 1'b0, 8'd41, 16'd10, 32'd7);
    cfg(2'd3, 1'b0, 8'd41, 16'd13, 32'd103);
    xact("worst", 2'd1, 8'd2, 2'd0, 32'd0, 1'b0, 6);
    xact("it_empty", 2'd0, 8'd0, 2'd0, 32'd0, 1'b0, 1);
    xact("no_alloc", 2'd1, 8'd2, 2'd0, 32'd0, 1'b1, 1);

    // Back-pressure: response held while rsp_ready is low
    cfg(2'd0, 1'b1, 8'd41, 16'd10, 32'd7);
    rsp_ready = 1'b0;
    send(2'd2, 8'd1, 2'd0);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold.valid", 32'(rsp_valid), 32'd1);
      check("hold.data", rsp_data, 32'd41);
      check("hold.ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rel.valid", 32'(rsp_valid), 32'd0);
    check("rel.ready", 32'(req_ready), 32'd1);

    // Reset during SEARCH
    cfg(2'd0, 1'b0, 8'd41, 16'd10, 32'd7);
    cfg(2'd3, 1'b1, 8'd32, 16'd13, 32'd5);
    send(2'd1, 8'd1, 2'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("srch.ready", 32'(req_ready), 32'd0);
    check("srch.valid", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mrst.valid", 32'(rsp_valid), 32'd0);
    check("mrst.ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    xact("mrst.empty", 2'd0, 8'd0, 2'd0, 32'd0, 1'b0, 1);
    xact("mrst.get", 2'd2, 8'd4, 2'd0, 32'd0, 1'b1, 1);
    xact("mrst.scan", 2'd1, 8'd1, 2'd0, 32'd0, 1'b1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
